// File: rtl/ovr_sdram_writer.sv
// rtl/ovr_sdram_writer.sv - overlay byte stream to SDRAM RGBA4444 word writer
//
// Pairs overlay download bytes into 16-bit words, buffers them in a small
// FIFO and drains the FIFO through a req/ack SDRAM write channel.
//
// Ports:
//   clk_sys, reset           clock, asynchronous active-high reset
//   sel                      current download is an overlay
//   ioctl_download/wr/addr/dout  hps_io download port (byte stream)
//   ioctl_wait               registered host backpressure
//   mem_req/addr/din/ack     SDRAM write channel (req held until ack)
//   busy                     load in progress or data still buffered
//   done                     one-cycle pulse when a load is fully written
//   overflow                 sticky: a word was dropped on a full FIFO
//   word_count               words acked since the load started
module ovr_sdram_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 24
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          sel,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW-1:0] word_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 16;

  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t state, state_nx;

  // Load tracking
  logic ov_now, ov_q, dl_q, loading, ended;
  logic start, fall;

  assign ov_now = ioctl_download & sel;
  assign start  = ov_now & ~ov_q;
  assign fall   = dl_q & ~ioctl_download & loading;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ov_q <= 1'b0;
      dl_q <= 1'b0;
    end else begin
      ov_q <= ov_now;
      dl_q <= ioctl_download;
    end
  end

  // Pending byte and pairing
  logic          pend_valid;
  logic [7:0]    pend_byte;
  logic [AW-1:0] pend_addr;
  logic          wr_ov, pv_eff;
  logic [AW-1:0] byte_waddr;
  logic          push, pend_set, pend_clr;
  logic [EW-1:0] push_entry;

  assign wr_ov      = ioctl_wr & ioctl_download & sel;
  assign byte_waddr = AW'(ioctl_addr[24:1]);
  // A load start in the same cycle as a byte sees no pending byte.
  assign pv_eff     = pend_valid & ~start;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    if (wr_ov) begin
      if (!ioctl_addr[0]) begin
        pend_set = 1'b1;
        if (pv_eff) begin
          push       = 1'b1;
          push_entry = {pend_addr, 8'h00, pend_byte};
        end
      end else begin
        pend_clr = 1'b1;
        push     = 1'b1;
        if (pv_eff && pend_addr == byte_waddr)
          push_entry = {byte_waddr, ioctl_dout, pend_byte};
        else
          push_entry = {byte_waddr, ioctl_dout, 8'h00};
      end
    end else if (fall && pend_valid) begin
      // End-of-load flush of a trailing even byte.
      push       = 1'b1;
      push_entry = {pend_addr, 8'h00, pend_byte};
      pend_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_byte  <= '0;
      pend_addr  <= '0;
    end else if (pend_set) begin
      pend_valid <= 1'b1;
      pend_byte  <= ioctl_dout;
      pend_addr  <= byte_waddr;
    end else if (pend_clr || start) begin
      pend_valid <= 1'b0;
    end
  end

  // FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr, wr_idx;
  logic [CW-1:0] count;
  logic          full_eff, push_ok, pop;

  assign full_eff = ~start & (count == CW'(FIFO_DEPTH));
  assign push_ok  = push & ~full_eff;
  assign pop      = (state == S_REQ) & mem_ack & ~start;
  assign wr_idx   = start ? '0 : wptr;

  always_ff @(posedge clk_sys) begin
    if (push_ok)
      fifo_mem[wr_idx] <= push_entry;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      if (start) begin
        rptr     <= '0;
        wptr     <= push_ok ? PW'(1) : '0;
        count    <= push_ok ? CW'(1) : '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (push && full_eff) overflow <= 1'b1;
      end
      // One slot of headroom for the word that may already be in flight.
      ioctl_wait <= (count >= CW'(FIFO_DEPTH - 1));
    end
  end

  // Drain FSM
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!start && count != '0) state_nx = S_REQ;
      S_REQ:   if (start || mem_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == S_REQ);
  end

  // Head entry stays in the FIFO until acked; only a copy is held here.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (state == S_IDLE && state_nx == S_REQ) begin
      {mem_addr, mem_din} <= fifo_mem[rptr];
    end
  end

  // Completion tracking
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      loading    <= 1'b0;
      ended      <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        loading    <= 1'b1;
        ended      <= 1'b0;
        word_count <= '0;
      end else begin
        if (pop) word_count <= word_count + 1'b1;
        if (fall) begin
          loading <= 1'b0;
          ended   <= 1'b1;
        end
        if (ended && !pend_valid && count == '0 && state == S_IDLE) begin
          done  <= 1'b1;
          ended <= 1'b0;
        end
      end
    end
  end

  assign busy = loading | pend_valid | (count != '0) | (state != S_IDLE);

endmodule

// File: tb/tb_ovr_sdram_writer.sv
// tb/tb_ovr_sdram_writer.sv - self-checking bench for ovr_sdram_writer
module tb_ovr_sdram_writer;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset, sel, ioctl_download, ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait, mem_req, busy, done, overflow;
  logic [AW-1:0] mem_addr, word_count;
  logic [15:0]   mem_din;
  logic          mem_ack = 1'b0;

  always #5 clk = ~clk;

  ovr_sdram_writer #(.FIFO_DEPTH(8), .AW(AW)) dut (
    .clk_sys(clk), .reset(reset), .sel(sel),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
  );

  int n_vec = 0;
  int n_fail = 0;
  bit ack_en = 0, ack_rand = 0, stray_ack = 0, auto_release = 0;
  bit wait_seen = 0;
  int words_at_wait = 0, sent_words = 0;
  logic [39:0] writes[$];
  int done_cnt = 0, req_cnt = 0, busy_cnt = 0, gap_err = 0;
  bit last_acc = 0;
  logic [24:0] ba[$];
  logic [7:0]  bd[$];
  logic [39:0] expq[$];

  typedef struct packed {
    logic [2:0]        nb;
    logic [3:0][24:0]  a;
    logic [3:0][7:0]   d;
    logic [2:0]        nw;
    logic [2:0][39:0]  w;
  } vec_t;
  vec_t tbl[7];

  // SDRAM side: one-cycle ack pulses, optionally at random delays.
  always @(posedge clk) begin
    #1;
    if (mem_ack) mem_ack = 1'b0;
    else if (stray_ack || (ack_en && mem_req && (!ack_rand || $urandom_range(0, 2) == 0)))
      mem_ack = 1'b1;
  end

  always @(negedge clk) begin
    if (last_acc && mem_req) gap_err++;
    last_acc = mem_req && mem_ack;
    if (mem_req && mem_ack) writes.push_back({mem_addr, mem_din});
    if (done) done_cnt++;
    if (mem_req) req_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: pairing rules applied to the whole byte list of one load.
  task automatic build_model();
    bit pv;
    logic [23:0] pa, wa;
    logic [7:0] pd;
    pv = 0; pa = '0; pd = '0;
    expq.delete();
    for (int i = 0; i < ba.size(); i++) begin
      wa = ba[i][24:1];
      if (!ba[i][0]) begin
        if (pv) expq.push_back({pa, 8'h00, pd});
        pv = 1; pa = wa; pd = bd[i];
      end else begin
        if (pv && pa == wa) expq.push_back({wa, bd[i], pd});
        else expq.push_back({wa, bd[i], 8'h00});
        pv = 0;
      end
    end
    if (pv) expq.push_back({pa, 8'h00, pd});
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honor);
    int c;
    c = 0;
    if (honor) begin
      while (ioctl_wait && c < 400) begin
        if (!wait_seen) begin
          wait_seen = 1;
          words_at_wait = sent_words;
        end
        c++;
        if (auto_release && c == 10) ack_en = 1;
        @(negedge clk);
      end
      if (c >= 400) check("wait_timeout", 64'(c), 64'd0);
    end
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic run_bytes(input bit honor);
    for (int i = 0; i < ba.size(); i++) begin
      sent_words = i / 2;
      send_byte(ba[i], bd[i], honor);
    end
  endtask

  task automatic begin_load(input bit s);
    sel = s; ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int c, d0;
    c = 0; d0 = done_cnt;
    while (done_cnt == d0 && c < 3000) begin @(negedge clk); c++; end
    if (c >= 3000) check("done_timeout", 64'(c), 64'd0);
    repeat (4) @(negedge clk);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic end_load();
    int c;
    c = 0;
    while (ioctl_wait && c < 1000) begin @(negedge clk); c++; end
    if (c >= 1000) check("end_wait_timeout", 64'(c), 64'd0);
    ioctl_download = 1'b0;
    wait_done();
  endtask

  task automatic compare_writes(input string nm, input int base, input int nexp);
    check({nm, "_nwords"}, 64'(writes.size() - base), 64'(nexp));
    for (int k = 0; k < nexp && base + k < writes.size(); k++)
      check({nm, "_word"}, 64'(writes[base + k]), 64'(expq[k]));
  endtask

  initial begin
    int base, rc, bc, dc, c, n;
    logic [24:0] a;

    tbl[0] = '{nb: 3'd4, a: {25'd3, 25'd2, 25'd1, 25'd0}, d: {8'h44, 8'h33, 8'h22, 8'h11},
               nw: 3'd2, w: {40'h0, 40'h000001_4433, 40'h000000_2211}};
    tbl[1] = '{nb: 3'd3, a: {25'd0, 25'd2, 25'd1, 25'd0}, d: {8'h00, 8'h33, 8'h22, 8'h11},
               nw: 3'd2, w: {40'h0, 40'h000001_0033, 40'h000000_2211}};
    tbl[2] = '{nb: 3'd2, a: {25'd0, 25'd0, 25'd6, 25'd4}, d: {8'h00, 8'h00, 8'hBB, 8'hAA},
               nw: 3'd2, w: {40'h0, 40'h000003_00BB, 40'h000002_00AA}};
    tbl[3] = '{nb: 3'd2, a: {25'd0, 25'd0, 25'd7, 25'd4}, d: {8'h00, 8'h00, 8'hBB, 8'hAA},
               nw: 3'd1, w: {40'h0, 40'h0, 40'h000003_BB00}};
    tbl[4] = '{nb: 3'd2, a: {25'd0, 25'd0, 25'd6, 25'd5}, d: {8'h00, 8'h00, 8'hDD, 8'hCC},
               nw: 3'd2, w: {40'h0, 40'h000003_00DD, 40'h000002_CC00}};
    tbl[5] = '{nb: 3'd2, a: {25'd0, 25'd0, 25'h1FFFFFF, 25'h1FFFFFE}, d: {8'h00, 8'h00, 8'h34, 8'h12},
               nw: 3'd1, w: {40'h0, 40'h0, 40'hFFFFFF_3412}};
    tbl[6] = '{nb: 3'd3, a: {25'd0, 25'd9, 25'd9, 25'd8}, d: {8'h00, 8'h03, 8'h02, 8'h01},
               nw: 3'd2, w: {40'h0, 40'h000004_0300, 40'h000004_0201}};

    reset = 1'b1; sel = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_din", 64'(mem_din), 64'd0);
    check("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single loads
    ack_en = 1; ack_rand = 0;
    for (int t = 0; t < 7; t++) begin
      ba.delete(); bd.delete(); expq.delete();
      for (int k = 0; k < int'(tbl[t].nb); k++) begin
        ba.push_back(tbl[t].a[k]);
        bd.push_back(tbl[t].d[k]);
      end
      for (int k = 0; k < int'(tbl[t].nw); k++) expq.push_back(tbl[t].w[k]);
      base = writes.size();
      begin_load(1); run_bytes(1); end_load();
      compare_writes("tbl", base, int'(tbl[t].nw));
      check("tbl_word_count", 64'(word_count), 64'(tbl[t].nw));
      check("tbl_overflow", 64'(overflow), 64'd0);
    end

    // Request latency and hold without ack
    ack_en = 0;
    base = writes.size();
    begin_load(1);
    send_byte(25'd1, 8'h5A, 1);
    check("lat_req_early", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("lat_req", 64'(mem_req), 64'd1);
    check("lat_addr", 64'(mem_addr), 64'd0);
    check("lat_din", 64'(mem_din), 64'h5A00);
    repeat (3) @(negedge clk);
    check("lat_req_held", 64'(mem_req), 64'd1);
    ack_en = 1;
    end_load();
    check("lat_nwords", 64'(writes.size() - base), 64'd1);

    // Backpressure honoured: no overflow, all ten words in order
    ba.delete(); bd.delete();
    for (int i = 0; i < 20; i++) begin ba.push_back(25'(i)); bd.push_back(8'(i * 7 + 3)); end
    build_model();
    ack_en = 0; auto_release = 1; wait_seen = 0;
    base = writes.size();
    begin_load(1); run_bytes(1);
    check("wait_seen", 64'(wait_seen), 64'd1);
    check("wait_at_words", 64'(words_at_wait), 64'd7);
    check("wait_overflow", 64'(overflow), 64'd0);
    end_load();
    auto_release = 0;
    compare_writes("wait", base, 10);

    // Backpressure ignored: overflow, only eight words survive
    ack_en = 0;
    base = writes.size();
    begin_load(1); run_bytes(0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_wait", 64'(ioctl_wait), 64'd1);
    ack_en = 1;
    end_load();
    compare_writes("ovf", base, 8);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_word_count", 64'(word_count), 64'd8);

    // Reset in the middle of a request
    ack_en = 0;
    begin_load(1);
    send_byte(25'd0, 8'hAA, 1);
    send_byte(25'd1, 8'hBB, 1);
    c = 0;
    while (!mem_req && c < 50) begin @(negedge clk); c++; end
    check("rst_mid_req_seen", 64'(mem_req), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b1; ioctl_download = 1'b0; sel = 1'b0;
    #1;
    check("rst_mid_mem_req", 64'(mem_req), 64'd0);
    check("rst_mid_word_count", 64'(word_count), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    rc = req_cnt;
    repeat (20) @(negedge clk);
    check("rst_mid_no_req", 64'(req_cnt - rc), 64'd0);
    check("rst_mid_busy_after", 64'(busy), 64'd0);

    // Non-overlay download plus a stray ack: no activity at all
    ack_en = 1;
    rc = req_cnt; bc = busy_cnt; dc = done_cnt;
    begin_load(0);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i + 1), 0);
    stray_ack = 1;
    @(negedge clk);
    stray_ack = 0;
    ioctl_download = 1'b0;
    repeat (10) @(negedge clk);
    check("nosel_req", 64'(req_cnt - rc), 64'd0);
    check("nosel_busy", 64'(busy_cnt - bc), 64'd0);
    check("nosel_done", 64'(done_cnt - dc), 64'd0);
    check("nosel_word_count", 64'(word_count), 64'd0);

    // Randomized loads against the pairing model
    ack_rand = 1;
    for (int r = 0; r < 5; r++) begin
      ba.delete(); bd.delete();
      n = $urandom_range(8, 40);
      a = 25'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) begin
        ba.push_back(a);
        bd.push_back(8'($urandom));
        if ($urandom_range(0, 9) < 8) a = a + 25'd1;
        else a = 25'($urandom_range(0, 63));
      end
      build_model();
      base = writes.size();
      begin_load(1); run_bytes(1); end_load();
      compare_writes("rnd", base, expq.size());
      check("rnd_word_count", 64'(word_count), 64'(expq.size()));
      check("rnd_overflow", 64'(overflow), 64'd0);
    end

    check("req_gap", 64'(gap_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
